uart_tx_frame: RTL

UART transmitter, the transmit-side counterpart of the UART_RX path. It accepts a parallel word on a valid strobe, frames it as start, data (LSB first), optional parity and stop, and drives the serial line. Each bit is held for PRESCALE clock cycles. All logic runs in one clock domain and the output is registered.

---
 rtl/uart_tx_frame_if.sv | 30 +++
 rtl/uart_tx_frame.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame_if.sv
// Request/serial bundle for the UART frame transmitter: the master drives the word and
// its framing options, the slave returns the serial line and the busy flag.
interface uart_tx_frame_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic                  par_en;
    logic                  par_typ;
    logic                  TX_OUT;
    logic                  busy;

    modport master (
        output P_DATA,
        output data_valid,
        output par_en,
        output par_typ,
        input  TX_OUT,
        input  busy
    );

    modport slave (
        input  P_DATA,
        input  data_valid,
        input  par_en,
        input  par_typ,
        output TX_OUT,
        output busy
    );
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmitter: frames a parallel word as start, LSB-first data, optional parity and
// stop, each bit held PRESCALE clocks. TX_OUT and busy come straight from flops.
module uart_tx_frame #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE   = 8
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_frame_if.slave bus
);
    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    state_e                state_q;
    state_e                state_d;
    logic [CNT_W-1:0]      clk_cnt_q;
    logic [CNT_W-1:0]      clk_cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q;
    logic [BIT_W-1:0]      bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] shift_d;
    logic                  par_en_q;
    logic                  par_en_d;
    logic                  par_bit_q;
    logic                  par_bit_d;
    logic                  tx_q;
    logic                  tx_d;
    logic                  busy_q;
    logic                  busy_d;
    logic                  bit_end_s;
    logic                  last_data_s;

    // Parity bit that goes on the wire: even parity sends the XOR of the data, odd inverts it.
    function automatic logic parity_f(input logic [DATA_WIDTH-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

    assign bit_end_s   = (clk_cnt_q == CNT_LAST);
    assign last_data_s = (bit_cnt_q == BIT_LAST);

    assign bus.TX_OUT = tx_q;
    assign bus.busy   = busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.data_valid) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_end_s && last_data_s) begin
                    state_d = par_en_q ? ST_PARITY : ST_STOP;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (bit_end_s) begin
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (bit_end_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the flopped line leads with the bit it enters.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = 1'b1;
        case (state_d)
            ST_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
            end
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = par_bit_d;
            ST_STOP:   tx_d = 1'b1;
            default: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        if (state_q == ST_IDLE) begin
            clk_cnt_d = '0;
            bit_cnt_d = '0;
            if (bus.data_valid) begin
                shift_d   = bus.P_DATA;
                par_en_d  = bus.par_en;
                par_bit_d = parity_f(bus.P_DATA, bus.par_typ);
            end else begin
                shift_d = shift_q;
            end
        end else if (bit_end_s) begin
            clk_cnt_d = '0;
            if (state_q == ST_DATA) begin
                shift_d = shift_q >> 1;
                if (last_data_s) begin
                    bit_cnt_d = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                end
            end else begin
                bit_cnt_d = '0;
            end
        end else begin
            clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
        end else begin
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
        end
    end
endmodule
